// File: rtl/spdif_pkg.sv
// spdif_pkg: shared constants and helpers for the S/PDIF (IEC 60958 consumer)
// transmitter. It holds the preamble patterns, the slot map of a subframe,
// the block/subframe sizes, the default channel-status word and the
// subframe selector type.
package spdif_pkg;

    // Preamble cell patterns for a preceding line level of 0. The first cell
    // sent is the MSB.
    localparam logic [7:0] PRE_B = 8'b11101000;  // left, first frame of block
    localparam logic [7:0] PRE_M = 8'b11100010;  // left, other frames
    localparam logic [7:0] PRE_W = 8'b11100100;  // right

    // Slot map of a 32-slot subframe.
    localparam logic [4:0] SLOT_AUDIO_LSB = 5'd4;
    localparam logic [4:0] SLOT_AUDIO_MSB = 5'd27;
    localparam logic [4:0] SLOT_V         = 5'd28;
    localparam logic [4:0] SLOT_U         = 5'd29;
    localparam logic [4:0] SLOT_C         = 5'd30;
    localparam logic [4:0] SLOT_P         = 5'd31;

    localparam int unsigned FRAMES_PER_BLOCK   = 192;
    localparam int unsigned CELLS_PER_SUBFRAME = 64;
    localparam int unsigned CELL_W             = $clog2(CELLS_PER_SUBFRAME);
    localparam int unsigned FRAME_W            = $clog2(FRAMES_PER_BLOCK);
    localparam logic [FRAME_W-1:0] LAST_FRAME  = FRAME_W'(FRAMES_PER_BLOCK - 1);

    // Default channel status: bit 2 = copy permitted, bit 25 = 48 kHz.
    localparam logic [FRAMES_PER_BLOCK-1:0] CS_DEFAULT =
        (FRAMES_PER_BLOCK'(1) << 2) | (FRAMES_PER_BLOCK'(1) << 25);

    typedef enum logic {
        SUB_LEFT  = 1'b0,
        SUB_RIGHT = 1'b1
    } subframe_t;

    // Preamble for the subframe about to start.
    function automatic logic [7:0] preamble_pattern(input subframe_t sub,
                                                    input logic block_start);
        if (sub == SUB_RIGHT) begin
            return PRE_W;
        end
        return block_start ? PRE_B : PRE_M;
    endfunction

endpackage

// File: rtl/spdif_cell_timer.sv
// spdif_cell_timer: fractional phase accumulator that produces a one-clock
// cell enable at an average rate of exactly CELL_RATE per second from a clock
// of CLK_FREQUENCY Hz.
//   clk      in   system clock
//   reset    in   asynchronous, active-high
//   cell_ce  out  high in the clock cycle whose rising edge advances one cell
module spdif_cell_timer
    import spdif_pkg::*;
#(
    parameter int unsigned CLK_FREQUENCY = 100_000_000,
    parameter int unsigned CELL_RATE     = 6_144_000
) (
    input  logic clk,
    input  logic reset,
    output logic cell_ce
);

    logic [31:0] acc;
    logic [32:0] acc_sum;
    logic [31:0] acc_next;

    // One extra bit on the sum so acc + CELL_RATE cannot wrap before the
    // comparison.
    always_comb begin
        acc_sum  = {1'b0, acc} + {1'b0, 32'(CELL_RATE)};
        cell_ce  = (acc_sum >= {1'b0, 32'(CLK_FREQUENCY)});
        acc_next = cell_ce ? 32'(acc_sum - {1'b0, 32'(CLK_FREQUENCY)})
                           : acc_sum[31:0];
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc <= '0;
        end else begin
            acc <= acc_next;
        end
    end

endmodule

// File: rtl/spdif_transmitter.sv
// spdif_transmitter: biphase-mark S/PDIF line encoder for 24-bit stereo PCM.
//   clk          in   system clock
//   reset        in   asynchronous, active-high
//   in_left      in   24-bit left sample, two's complement
//   in_right     in   24-bit right sample
//   in_valid     in   sample pair present
//   in_ready     out  holding buffer empty
//   tos_out      out  biphase-mark line level to the optical transmitter
//   frame_start  out  one-cycle pulse when a B/M preamble begins
//   underrun     out  one-cycle pulse when a frame starts with no pair held
module spdif_transmitter
    import spdif_pkg::*;
#(
    parameter int unsigned                  CLK_FREQUENCY = 100_000_000,
    parameter int unsigned                  SAMPLE_RATE   = 48_000,
    parameter logic [FRAMES_PER_BLOCK-1:0]  CS_WORD       = CS_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [23:0] in_left,
    input  logic [23:0] in_right,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        tos_out,
    output logic        frame_start,
    output logic        underrun
);

    // 32 slots of 2 cells per subframe, 2 subframes per frame.
    localparam int unsigned CELL_RATE = SAMPLE_RATE * 128;

    logic               cell_ce;
    logic [CELL_W-1:0]  cell_cnt;
    subframe_t          sub;
    logic [FRAME_W-1:0] frame_cnt;
    logic               pre_level;

    logic [23:0]        hold_left;
    logic [23:0]        hold_right;
    logic               hold_full;
    logic [23:0]        tx_left;
    logic [23:0]        tx_right;
    logic               tx_v;

    logic [4:0]         slot;
    logic [4:0]         audio_idx;
    logic [23:0]        sample;
    logic               cs_bit;
    logic               parity;
    logic               data_bit;
    logic [7:0]         pattern;
    logic               pre_ref;
    logic               cell_value;
    logic               frame_begin;
    logic               xfer;

    spdif_cell_timer #(
        .CLK_FREQUENCY(CLK_FREQUENCY),
        .CELL_RATE    (CELL_RATE)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .cell_ce(cell_ce)
    );

    assign in_ready    = ~hold_full;
    assign xfer        = in_valid & ~hold_full;
    assign frame_begin = cell_ce & (sub == SUB_LEFT) & (cell_cnt == '0);

    assign slot      = cell_cnt[CELL_W-1:1];
    assign audio_idx = slot - SLOT_AUDIO_LSB;
    assign sample    = (sub == SUB_LEFT) ? tx_left : tx_right;
    assign cs_bit    = CS_WORD[frame_cnt];
    // U is always 0, so only audio, V and C contribute to even parity.
    assign parity    = ^{sample, tx_v, cs_bit};

    always_comb begin
        // NOTE: assign a default before any branch so no path leaves the
        // signal unassigned, which would infer a latch.
        data_bit = 1'b0;
        if (slot >= SLOT_AUDIO_LSB && slot <= SLOT_AUDIO_MSB) begin
            data_bit = sample[audio_idx];
        end else if (slot == SLOT_V) begin
            data_bit = tx_v;
        end else if (slot == SLOT_C) begin
            data_bit = cs_bit;
        end else if (slot == SLOT_P) begin
            data_bit = parity;
        end
    end

    // Preambles are sent as raw cells relative to the level at the end of the
    // previous subframe; that level is still on tos_out at cell 0 and is kept
    // in pre_level for cells 1-7.
    assign pattern = preamble_pattern(sub, frame_cnt == '0);
    assign pre_ref = (cell_cnt == '0) ? tos_out : pre_level;

    always_comb begin
        cell_value = 1'b0;
        if (slot < SLOT_AUDIO_LSB) begin
            cell_value = pattern[3'd7 - cell_cnt[2:0]] ^ pre_ref;
        end else if (!cell_cnt[0]) begin
            cell_value = ~tos_out;               // every bit starts with an edge
        end else begin
            cell_value = tos_out ^ data_bit;     // mid-bit edge only for a 1
        end
    end

    // Line output and position counters; everything advances on cell_ce only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tos_out   <= 1'b0;
            pre_level <= 1'b0;
            cell_cnt  <= '0;
            sub       <= SUB_LEFT;
            frame_cnt <= '0;
        end else if (cell_ce) begin
            tos_out  <= cell_value;
            cell_cnt <= cell_cnt + 1'b1;
            if (cell_cnt == '0) begin
                pre_level <= tos_out;
            end
            if (cell_cnt == '1) begin
                sub <= (sub == SUB_LEFT) ? SUB_RIGHT : SUB_LEFT;
                if (sub == SUB_RIGHT) begin
                    frame_cnt <= (frame_cnt == LAST_FRAME) ? '0 : frame_cnt + 1'b1;
                end
            end
        end
    end

    // Holding buffer and transmit register. A frame start consumes what was
    // held before this edge; a same-edge transfer (only possible when the
    // buffer was empty) refills it, so the later assignment wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the sample registers are reset along with their valid flag;
            // they are few, and it keeps underrun frames free of stale data.
            hold_left  <= '0;
            hold_right <= '0;
            hold_full  <= 1'b0;
            tx_left    <= '0;
            tx_right   <= '0;
            tx_v       <= 1'b0;
        end else begin
            if (frame_begin) begin
                tx_left   <= hold_full ? hold_left  : 24'd0;
                tx_right  <= hold_full ? hold_right : 24'd0;
                tx_v      <= ~hold_full;
                hold_full <= 1'b0;
            end
            if (xfer) begin
                hold_left  <= in_left;
                hold_right <= in_right;
                hold_full  <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_start <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            frame_start <= frame_begin;
            underrun    <= frame_begin & ~hold_full;
        end
    end

endmodule

// File: tb/tb_spdif_transmitter.sv
// tb_spdif_transmitter: scoreboard bench for spdif_transmitter. A fast-clock
// instance is decoded cell by cell with the bench's own cell-rate model; a
// default-parameter instance is used for cell timing.
module tb_spdif_transmitter;

    localparam int unsigned FAST_CLK  = 9_216_000;   // 1.5 clocks per cell
    localparam int unsigned CELL_RATE = 6_144_000;   // 48 kHz * 128
    localparam logic [191:0] CS_EXP   = 192'h2000004; // bits 2 and 25

    typedef struct packed {
        logic [23:0] l;
        logic [23:0] r;
        logic        v;
    } frame_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [23:0] in_left = '0;
    logic [23:0] in_right = '0;
    logic        in_valid = 1'b0;
    logic        in_ready, tos_out, frame_start, underrun;

    logic        ref_valid = 1'b0;
    logic        ref_ready, ref_tos, ref_fs, ref_ur;

    always #5 clk = ~clk;

    spdif_transmitter #(.CLK_FREQUENCY(FAST_CLK), .SAMPLE_RATE(48_000)) dut (
        .clk(clk), .reset(reset), .in_left(in_left), .in_right(in_right),
        .in_valid(in_valid), .in_ready(in_ready), .tos_out(tos_out),
        .frame_start(frame_start), .underrun(underrun)
    );

    spdif_transmitter dut_ref (
        .clk(clk), .reset(reset), .in_left(24'd0), .in_right(24'd0),
        .in_valid(ref_valid), .in_ready(ref_ready), .tos_out(ref_tos),
        .frame_start(ref_fs), .underrun(ref_ur)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [191:0] actual,
                         input logic [191:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Scoreboard state.
    frame_t      hold_q[$];   // pairs accepted but not yet claimed by a frame
    frame_t      frame_q[$];  // expected content of frames on the line
    logic [32:0] m_acc = '0;
    int          dec_idx = 0;
    logic        dec_sub = 1'b0;
    int          frame_idx = 0;
    int          frames_done = 0;
    logic        prev_level = 1'b0;
    logic [63:0] cells = '0;
    logic        left_c = 1'b0;
    logic [191:0] cs_seen = '0;
    logic        cs_done = 1'b0;
    logic        stream_mode = 1'b0;
    logic        ref_done = 1'b0;

    task automatic decode_subframe();
        logic [7:0]  pre, exp_pre;
        logic [31:0] bits;
        logic        bp_ok;
        frame_t      f;
        bits  = '0;
        bp_ok = 1'b1;
        for (int i = 0; i < 8; i++) pre[7-i] = cells[i] ^ prev_level;
        if (dec_sub) exp_pre = 8'hE4;
        else         exp_pre = (frame_idx % 192 == 0) ? 8'hE8 : 8'hE2;
        check($sformatf("preamble f%0d s%0d", frame_idx, dec_sub), pre, exp_pre);
        for (int s = 4; s < 32; s++) begin
            if (cells[2*s] == cells[2*s-1]) bp_ok = 1'b0;
            bits[s] = cells[2*s] ^ cells[2*s+1];
        end
        check("biphase_edges", bp_ok, 1'b1);
        check("parity_even", ^bits[31:4], 1'b0);
        check("u_bit", bits[29], 1'b0);
        if (frame_q.size() == 0) begin
            check("frame_expected", 1'b0, 1'b1);
        end else begin
            f = frame_q[0];
            check($sformatf("sample f%0d s%0d", frame_idx, dec_sub), bits[27:4],
                  dec_sub ? f.r : f.l);
            check($sformatf("v_bit f%0d s%0d", frame_idx, dec_sub), bits[28], f.v);
            if (dec_sub) void'(frame_q.pop_front());
        end
        if (!dec_sub) begin
            left_c = bits[30];
        end else begin
            check("c_left_right", bits[30], left_c);
            if (frame_idx < 192) cs_seen[frame_idx] = bits[30];
            if (frame_idx == 191) begin
                check("cs_block", cs_seen, CS_EXP);
                cs_done = 1'b1;
            end
            frames_done++;
        end
    endtask

    task automatic decode_cell(input logic v);
        cells[dec_idx] = v;
        if (dec_idx == 63) begin
            decode_subframe();
            prev_level = cells[63];
            dec_idx = 0;
            if (dec_sub) frame_idx++;
            dec_sub = ~dec_sub;
        end else begin
            dec_idx++;
        end
    endtask

    // Monitor: tracks the handshake, predicts frame contents and decodes the
    // line on the bench's own cell schedule.
    initial begin : monitor
        logic   ce, fb, xfer, exp_ur;
        frame_t f;
        forever begin
            @(posedge clk);
            if (reset) begin
                hold_q.delete();
                frame_q.delete();
                m_acc = '0;
                dec_idx = 0;
                dec_sub = 1'b0;
                frame_idx = 0;
                prev_level = 1'b0;
                cs_seen = '0;
                continue;
            end
            xfer   = in_valid && in_ready;
            ce     = (m_acc + 33'(CELL_RATE)) >= 33'(FAST_CLK);
            m_acc  = ce ? m_acc + 33'(CELL_RATE) - 33'(FAST_CLK) : m_acc + 33'(CELL_RATE);
            fb     = ce && !dec_sub && dec_idx == 0;
            exp_ur = 1'b0;
            if (fb) begin
                if (hold_q.size() > 0) f = hold_q.pop_front();
                else                   f = '{l: 24'd0, r: 24'd0, v: 1'b1};
                exp_ur = f.v;
                frame_q.push_back(f);
            end
            if (xfer) hold_q.push_back('{l: in_left, r: in_right, v: 1'b0});
            #1;
            if (frame_start || underrun || fb) begin
                check("frame_start", frame_start, fb);
                check("underrun", underrun, exp_ur);
            end
            if (fb && stream_mode) check("no_underrun_stream", underrun, 1'b0);
            check("in_ready", in_ready, hold_q.size() == 0);
            if (ce) decode_cell(tos_out);
        end
    end

    // Cell timing of the default-parameter instance: 20000 clocks after reset
    // hold floor(20000 * 6144000 / 1e8) = 1228 cells, gaps of 16 or 17 clocks.
    initial begin : ref_timing
        int cnt, last;
        cnt = 0;
        last = 0;
        wait (reset == 1'b0);
        for (int k = 1; k <= 20000; k++) begin
            @(posedge clk);
            if (dut_ref.u_timer.cell_ce) begin
                cnt++;
                if (last > 0) check($sformatf("cell_gap %0d", k - last),
                                    (k - last == 16) || (k - last == 17), 1'b1);
                last = k;
            end
        end
        check($sformatf("cell_count %0d", cnt), cnt >= 1227 && cnt <= 1229, 1'b1);
        ref_done = 1'b1;
    end

    task automatic send_pair(input logic [23:0] l, input logic [23:0] r);
        logic ok;
        ok = 1'b0;
        @(negedge clk);
        in_left  = l;
        in_right = r;
        in_valid = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(negedge clk);
        if (!ok) check("handshake_timeout", 1'b0, 1'b1);
    endtask

    task automatic wait_frames(input int n, input string name);
        int target;
        target = frames_done + n;
        for (int i = 0; i < n * 400 + 400; i++) begin
            @(negedge clk);
            if (frames_done >= target) return;
        end
        check({name, "_timeout"}, 1'b0, 1'b1);
    endtask

    initial begin : stimulus
        logic hit;
        repeat (3) @(negedge clk);
        check("rst_tos_out", tos_out, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_frame_start", frame_start, 1'b0);
        check("rst_underrun", underrun, 1'b0);
        reset = 1'b0;

        // Idle: first frames are underruns with zero data and V=1.
        wait_frames(2, "idle");

        send_pair(24'h000001, 24'h800000);
        in_valid = 1'b0;
        wait_frames(3, "single");

        // Back-to-back pairs with in_valid held high.
        send_pair(24'h123456, 24'hABCDEF);
        stream_mode = 1'b1;
        send_pair(24'h7FFFFF, 24'h000000);
        send_pair(24'h800001, 24'h5A5A5A);
        send_pair(24'hFFFFFF, 24'h0F0F0F);
        in_valid = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 1000 && !hit; i++) begin
            @(negedge clk);
            hit = frame_start;
        end
        if (!hit) check("last_pair_frame_timeout", 1'b0, 1'b1);
        stream_mode = 1'b0;

        // Run past the end of the first 192-frame block.
        wait_frames(201 - frames_done, "block");

        // Reset in slot 15 of a right subframe with a pair held.
        hit = 1'b0;
        for (int i = 0; i < 1000 && !hit; i++) begin
            @(negedge clk);
            hit = dec_sub && dec_idx < 8;
        end
        if (!hit) check("right_sub_timeout", 1'b0, 1'b1);
        send_pair(24'h111111, 24'h222222);
        in_valid = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 1000 && !hit; i++) begin
            hit = dec_sub && dec_idx == 31;
            if (!hit) @(negedge clk);
        end
        if (!hit) check("slot15_timeout", 1'b0, 1'b1);
        check("held_before_reset", in_ready, 1'b0);
        reset = 1'b1;
        #1;
        check("mid_rst_tos_out", tos_out, 1'b0);
        check("mid_rst_in_ready", in_ready, 1'b1);
        check("mid_rst_frame_start", frame_start, 1'b0);
        repeat (4) @(negedge clk);
        reset = 1'b0;
        wait_frames(2, "after_reset");

        check("cs_block_seen", cs_done, 1'b1);
        for (int i = 0; i < 30000 && !ref_done; i++) @(negedge clk);
        check("ref_timing_done", ref_done, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
